// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares the single-ported data memory between the CPU MEM
// stage and a DMA/loader port.
//
// The CPU path is purely combinational, so CPU accesses add no latency. A
// DMA access takes one dedicated memory cycle (DMA_XFER). dma_ack and
// dma_rdata follow in the next cycle (DMA_ACK). The CPU stalls only when it
// requests the memory during DMA_XFER.
//
// Optional feature, build macro DMEM_ARB_FAIRNESS_EN:
//   When defined, a saturating wait counter forces a pending DMA in after
//   MAX_WAIT contended cycles. When undefined, the CPU always has priority.
//
// Parameters:
//   MAX_WAIT   contended cycles before a DMA is forced in (1..255)
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   cpu_req/we/addr/wdata -> cpu_rdata  CPU MEM stage access, load data
//   cpu_stall                           CPU access not performed this cycle
//   dma_req/we/addr/wdata               DMA request, held until dma_ack
//   dma_rdata, dma_ack                  registered read data, done pulse
//   mem_read/write/addr/wdata           to the data memory
//   mem_rdata                           from the data memory (comb)
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, DMA_XFER, DMA_ACK} state_t;

    state_t state;
    logic   starve;
    logic   go;
    logic   dma_own;

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);
    logic [7:0] wait_cnt;

    assign starve = (wait_cnt >= WAIT_MAX);

    // Counts contended IDLE cycles. A cycle in IDLE with dma_req held and no
    // transition is contended by construction. The count saturates at
    // WAIT_MAX, and starve stays high until the DMA is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (state == IDLE) begin
            if (go || !dma_req)
                wait_cnt <= 8'd0;
            else if (wait_cnt < WAIT_MAX)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    // Strict CPU priority. This is constant 0 for any legal MAX_WAIT (>= 1).
    assign starve = (MAX_WAIT == 0);
`endif

    assign go      = (state == IDLE) && dma_req && (!cpu_req || starve);
    assign dma_own = (state == DMA_XFER);

    // DMA_ACK ignores dma_req, so a request held through its ack is not
    // served twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dma_ack   <= 1'b0;
            dma_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    dma_ack <= 1'b0;
                    if (go)
                        state <= DMA_XFER;
                end
                DMA_XFER: begin
                    if (!dma_we)
                        dma_rdata <= mem_rdata;
                    dma_ack <= 1'b1;
                    state   <= DMA_ACK;
                end
                DMA_ACK: begin
                    dma_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    dma_ack <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_read  = cpu_req && !cpu_we;
        mem_write = cpu_req && cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
        cpu_stall = 1'b0;
        if (dma_own) begin
            mem_read  = !dma_we;
            mem_write = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            cpu_rdata = 32'd0;
            cpu_stall = cpu_req;
        end
        // Keep the memory quiet while reset is held. This also stops the
        // negedge commit of a DMA write that reset aborts.
        if (!rst_n) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            cpu_stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ack;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory: combinational read, write commits on the negedge.
    logic [31:0] mem [256] = '{default: 32'd0};
    assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'd0;
    always @(negedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

    // Bench-side reference contents and DMA scoreboard.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } dma_t;

    logic [31:0] ref_mem [256];
    dma_t        dma_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, req_cyc = 0, ack_cyc = 0, first_idle = 0;
    int stall_cnt = 0, ack_cnt = 0, dma_mem_cnt = 0;
    bit ack_flag = 0, drop_dma = 0, prev_ack = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic cpu(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic dma_issue(input logic we, input logic [31:0] a, input logic [31:0] d);
        dma_t e;
        e.we = we; e.addr = a; e.data = d;
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
        dma_q.push_back(e);
        req_cyc  = cyc;
        ack_flag = 0;
    endtask

    // Per-cycle monitor, run after the negedge write commit.
    task automatic mon();
        dma_t e;
        if (dma_ack) begin
            chk("ack_pulse_width", 32'(prev_ack), 32'd0);
            ack_cnt++; ack_cyc = cyc; ack_flag = 1; drop_dma = 1;
            if (dma_q.size() == 0) begin
                chk("dma_ack_unexpected", 32'd1, 32'd0);
            end else begin
                e = dma_q.pop_front();
                if (e.we) ref_mem[widx(e.addr)] = e.data;
                else      chk("dma_rdata", dma_rdata, ref_mem[widx(e.addr)]);
            end
        end
        prev_ack = dma_ack;
        if (cpu_stall) stall_cnt++;
        if (dma_req && !cpu_req && (mem_read || mem_write)) dma_mem_cnt++;
        if (cpu_req && !cpu_stall) begin
            if (cpu_we) ref_mem[widx(cpu_addr)] = cpu_wdata;
            else        chk("cpu_rdata", cpu_rdata, ref_mem[widx(cpu_addr)]);
        end
    endtask

    // Called at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic step();
        #6;
        mon();
        @(posedge clk); #1;
        cyc++;
        if (drop_dma) begin dma_req = 1'b0; drop_dma = 0; end
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (!ack_flag && n < budget) begin step(); n++; end
        if (!ack_flag) chk("dma_ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        rst_n = 1'b0;
        cpu(1'b1, 1'b0, 32'h10, 32'd0);
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;

        // Reset state, with a CPU request present to show the gating.
        @(posedge clk); #3;
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // CPU store then load, no DMA.
        stall_cnt = 0;
        cpu(1'b1, 1'b1, 32'h10, 32'hCAFEF00D); step();
        cpu(1'b1, 1'b0, 32'h10, 32'd0);
        #6; chk("t1_load_data", cpu_rdata, 32'hCAFEF00D); #(-6 + 6);
        mon(); @(posedge clk); #1; cyc++;
        chk("t1_no_stall", 32'(stall_cnt), 32'd0);

        // DMA write with CPU idle, then CPU load of the same word.
        cpu(1'b0, 1'b0, 32'd0, 32'd0);
        dma_issue(1'b1, 32'h40, 32'h12345678);
        wait_ack(8);
        chk("t2_ack_latency", 32'(ack_cyc - req_cyc), 32'd2);
        cpu(1'b1, 1'b0, 32'h40, 32'd0);
        #6; chk("t2_load_data", cpu_rdata, 32'h12345678);
        mon(); @(posedge clk); #1; cyc++;
        cpu(1'b0, 1'b0, 32'd0, 32'd0); step();

        // DMA read during a CPU load burst.
        stall_cnt = 0;
        dma_issue(1'b0, 32'h10, 32'd0);
        for (int i = 0; i < 10; i++) begin
            cpu(1'b1, 1'b0, 32'h40, 32'd0);
            step();
        end
`ifdef DMEM_ARB_FAIRNESS_EN
        chk("t3_ack_in_burst", 32'(ack_flag), 32'd1);
        chk("t3_ack_latency", 32'(ack_cyc - req_cyc), 32'd6);
        chk("t3_stall_cycles", 32'(stall_cnt), 32'd1);
        cpu(1'b0, 1'b0, 32'd0, 32'd0);
        step();
`else
        chk("t3_no_ack_in_burst", 32'(ack_flag), 32'd0);
        cpu(1'b0, 1'b0, 32'd0, 32'd0);
        first_idle = cyc;
        wait_ack(6);
        chk("t3_ack_after_idle", 32'(ack_cyc - first_idle), 32'd2);
        chk("t3_stall_cycles", 32'(stall_cnt), 32'd0);
`endif

        // DMA holds dma_req through DMA_ACK: one access, one ack.
        step();
        ack_cnt = 0; dma_mem_cnt = 0;
        dma_issue(1'b0, 32'h40, 32'd0);
        for (int i = 0; i < 6; i++) step();
        chk("t4_ack_count", 32'(ack_cnt), 32'd1);
        chk("t4_mem_accesses", 32'(dma_mem_cnt), 32'd1);

        // Reset pulsed in the middle of a DMA write.
        dma_issue(1'b1, 32'h80, 32'hDEADBEEF);
        step();                              // now at posedge+1 of DMA_XFER
        cpu(1'b1, 1'b0, 32'h80, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_ack", 32'(dma_ack), 32'd0);
        chk("t5_rst_mem_read", 32'(mem_read), 32'd0);
        chk("t5_rst_mem_write", 32'(mem_write), 32'd0);
        chk("t5_rst_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        cyc++;
        chk("t5_rst_ack_held", 32'(dma_ack), 32'd0);
        dma_req = 1'b0; dma_q.delete(); ack_flag = 0; drop_dma = 0; prev_ack = 0;
        rst_n = 1'b1;
        ack_cnt = 0;
        #6;
        chk("t5_post_rst_stall", 32'(cpu_stall), 32'd0);
        chk("t5_write_aborted", cpu_rdata, 32'd0);
        mon(); @(posedge clk); #1; cyc++;
        cpu(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) step();
        chk("t5_no_ack_after_rst", 32'(ack_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory of the 5-stage pipeline. It shares the memory between the CPU MEM stage and a DMA/loader port. CPU accesses pass through with zero added latency. DMA accesses take one dedicated memory cycle and stall the CPU only when the two collide. An optional starvation counter guarantees DMA forward progress under continuous CPU traffic.

## Interface
Parameters:
- MAX_WAIT, 8: number of contended cycles a pending DMA request waits before it is forced in (fairness build only); legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU MEM stage access valid this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; combinational.
- cpu_stall  out  1  CPU access not performed this cycle; pipeline must hold.
- dma_req  in  1  DMA access pending; held stable with dma_we/addr/wdata until dma_ack.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  32  byte address.
- dma_wdata  in  32  write data.
- dma_rdata  out  32  registered read data, valid while dma_ack = 1.
- dma_ack  out  1  one-cycle completion pulse.
- mem_read  out  1  to data memory MemRead.
- mem_write  out  1  to data memory MemWrite.
- mem_addr  out  32  to data memory addr.
- mem_wdata  out  32  to data memory writeData.
- mem_rdata  in  32  from data memory readData; combinational, 0 when mem_read = 0.

## Operation
FSM states: IDLE, DMA_XFER, DMA_ACK.

IDLE and DMA_ACK:
- The CPU owns the memory.
- mem_read = cpu_req & ~cpu_we; mem_write = cpu_req & cpu_we.
- mem_addr = cpu_addr; mem_wdata = cpu_wdata; cpu_rdata = mem_rdata; cpu_stall = 0.

IDLE exit:
- Go to DMA_XFER when dma_req & (~cpu_req | starve).
- starve = (wait_cnt >= MAX_WAIT), fairness build only.
- Otherwise stay in IDLE.

DMA_XFER:
- The DMA owns the memory.
- mem_read = ~dma_we; mem_write = dma_we; mem_addr = dma_addr; mem_wdata = dma_wdata.
- cpu_stall = cpu_req; cpu_rdata = 0.
- At posedge: dma_rdata <= dma_we ? dma_rdata : mem_rdata; dma_ack <= 1; go to DMA_ACK.

DMA_ACK:
- Lasts one cycle with dma_ack = 1. dma_req is ignored, so a held request is not served twice.
- Always returns to IDLE.

wait_cnt (width 8, saturating at MAX_WAIT):
- Increments in IDLE when dma_req & cpu_req and no transition occurs.
- Cleared on entry to DMA_XFER, and in IDLE when dma_req = 0.

Writes:
- Memory writes commit on the negedge inside the owning cycle, so a DMA write is visible to a CPU load in the first cycle after DMA_XFER.
- No address translation. The full 32-bit address is forwarded and the memory decodes addr[9:2].

## Timing
- CPU access latency: 0 cycles when not stalled.
- DMA latency: dma_req sampled in IDLE at posedge N → DMA_XFER during cycle N+1 → dma_ack and dma_rdata valid during cycle N+2.
- Minimum DMA issue interval: 3 cycles.
- Max CPU stall per DMA access: 1 cycle.
- Simultaneous cpu_req & dma_req in IDLE: CPU wins unless starve = 1.
- Reset values (rst_n low, asynchronous): state = IDLE, dma_ack = 0, dma_rdata = 0, wait_cnt = 0.
- While rst_n is low: mem_read = mem_write = 0 and cpu_stall = 0.
- Reset during DMA_XFER aborts the access and issues no dma_ack. If reset asserts after the negedge, the write has already committed.

## Configuration
- DMEM_ARB_FAIRNESS_EN defined: the starvation counter is present. After MAX_WAIT contended cycles the DMA is forced in and the CPU stalls one cycle.
- DMEM_ARB_FAIRNESS_EN not defined: strict CPU priority, starve is constant 0, and wait_cnt is removed. The DMA is served only in cycles where cpu_req = 0 in IDLE.

## Test plan
- CPU store then load, no DMA: store addr 0x10 data 0xCAFEF00D, then load 0x10. Required: cpu_stall never 1, cpu_rdata = 0xCAFEF00D in the load cycle.
- DMA write with CPU idle: dma_req, dma_we = 1, addr 0x40, data 0x12345678. Required: dma_ack 2 cycles after request; a following CPU load of 0x40 returns 0x12345678.
- DMA read during a CPU load burst, fairness build, MAX_WAIT = 4. Required: 4 contended cycles, then DMA_XFER with cpu_stall = 1 for exactly one cycle, dma_ack next cycle with correct dma_rdata.
- Same stimulus, non-fairness build. Required: no dma_ack while cpu_req stays 1; DMA completes within 2 cycles of the first cpu_req = 0 cycle.
- DMA holds dma_req through DMA_ACK. Required: exactly one memory access and one dma_ack per request.
- rst_n pulsed low mid DMA_XFER. Required: dma_ack = 0, state IDLE, mem_read = mem_write = 0 while in reset; next CPU access served unstalled.
